// File: rtl/pipe_pkg.sv
//==============================================================================
// Module      : pipe_pkg
// Description : Shared OoO pipeline constants and types (PR numbering, free list sizing).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_pkg;

   localparam int NUM_PR   = 64;
   localparam int NUM_AR   = 32;
   localparam int PR_W     = 6;
   localparam int ROB_W    = 4;
   localparam int FL_DEPTH = NUM_PR - NUM_AR;
   localparam int FL_PTR_W = $clog2(FL_DEPTH);

   typedef logic [PR_W-1:0] pr_t;

endpackage

`default_nettype wire

// File: rtl/fl_ptr_cnt.sv
//==============================================================================
// Module      : fl_ptr_cnt
// Description : Head/tail pointers and occupancy count of the PR free list.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fl_ptr_cnt
   import pipe_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc,
   input  logic                push,
   input  logic                restore,
   output logic [FL_PTR_W-1:0] head,
   output logic [FL_PTR_W-1:0] tail,
   output logic [FL_PTR_W:0]   count
);

   localparam logic [FL_PTR_W:0]   c_cnt_one   = (FL_PTR_W+1)'(1);
   localparam logic [FL_PTR_W:0]   c_cnt_reset = (FL_PTR_W+1)'(FL_DEPTH);
   localparam logic [FL_PTR_W-1:0] c_ptr_one   = FL_PTR_W'(1);

   logic [FL_PTR_W-1:0] r_head;
   logic [FL_PTR_W-1:0] r_tail;
   logic [FL_PTR_W:0]   r_count;
   logic [FL_PTR_W:0]   w_count_nxt;

   // alloc and restore never coincide because recovery blocks allocation
   always_comb begin
      w_count_nxt = r_count;
      if (push)    w_count_nxt = w_count_nxt + c_cnt_one;
      if (restore) w_count_nxt = w_count_nxt + c_cnt_one;
      if (alloc)   w_count_nxt = w_count_nxt - c_cnt_one;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= c_cnt_reset;
      end else begin
         if (alloc)        r_head <= r_head + c_ptr_one;
         else if (restore) r_head <= r_head - c_ptr_one;
         if (push)         r_tail <= r_tail + c_ptr_one;
         r_count <= w_count_nxt;
      end
   end

   assign head  = r_head;
   assign tail  = r_tail;
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/free_list.sv
//==============================================================================
// Module      : free_list
// Description : Circular FIFO of unallocated physical register numbers with
//               youngest-first recovery rollback. FREELIST_DUP_CHECK_EN adds
//               an in-list bitmap and a sticky err output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module free_list
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   input  logic              hazard_stall,
   output pr_t               alloc_pr,
   output logic              alloc_ok,
   input  logic              free_valid,
   input  pr_t               free_pr,
   input  logic              recover,
   input  logic              rec_restore,
   input  pr_t               rec_pr,
   output logic              empty,
   output logic              full,
   output logic [FL_PTR_W:0] count
`ifdef FREELIST_DUP_CHECK_EN
   ,
   output logic              err
`endif
);

   localparam logic [FL_PTR_W:0] c_full_cnt = (FL_PTR_W+1)'(FL_DEPTH);

   logic [FL_PTR_W-1:0] w_head;
   logic [FL_PTR_W-1:0] w_tail;
   logic                w_push;
   logic                w_restore;
   pr_t                 r_fifo [FL_DEPTH];

   assign empty     = (count == '0);
   assign full      = (count == c_full_cnt);
   assign alloc_ok  = alloc_req && !empty && !hazard_stall && !recover;
   assign w_push    = free_valid && !full;
   assign w_restore = recover && rec_restore;
   assign alloc_pr  = r_fifo[w_head];

   fl_ptr_cnt u_ptr_cnt (
      .clk     (clk),
      .rst     (rst),
      .alloc   (alloc_ok),
      .push    (w_push),
      .restore (w_restore),
      .head    (w_head),
      .tail    (w_tail),
      .count   (count)
   );

   // Array is flop-based so an async reset restores the PR32..63 image
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FL_DEPTH; i++) r_fifo[i] <= pr_t'(NUM_AR + i);
      end else if (w_push) begin
         r_fifo[w_tail] <= free_pr;
      end
   end

`ifdef FREELIST_DUP_CHECK_EN
   logic [NUM_PR-1:0]   r_in_list;
   logic [NUM_PR-1:0]   w_in_list_nxt;
   logic [FL_PTR_W-1:0] w_head_prev;
   logic                w_err_set;
   logic                r_err;

   assign w_head_prev = w_head - FL_PTR_W'(1);

   always_comb begin
      w_in_list_nxt = r_in_list;
      if (alloc_ok)  w_in_list_nxt[alloc_pr] = 1'b0;
      if (w_push)    w_in_list_nxt[free_pr]  = 1'b1;
      if (w_restore) w_in_list_nxt[rec_pr]   = 1'b1;
   end

   assign w_err_set = (free_valid && full)
                   || (w_push && r_in_list[free_pr])
                   || (w_restore && (rec_pr != r_fifo[w_head_prev]));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_list <= {{FL_DEPTH{1'b1}}, {NUM_AR{1'b0}}};
         r_err     <= 1'b0;
      end else begin
         r_in_list <= w_in_list_nxt;
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

endmodule

`default_nettype wire
